multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Sequential main controller for the multicycle RV32I core. It replaces the single-cycle
//  combinational main decoder. Sits between the instruction register (op) and the datapath
//  muxes/enables. Sequences FETCH/DECODE/EXECUTE/MEM/WB over several clocks, with an
//  optional memory-ready handshake, I-type ALU and JAL support, and illegal-opcode trapping.
// PARAMETERS
//  MEM_WAIT  1  1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0: mem_ready ignored (1-cycle mem)
//  EN_ITYPE  1  1: op 0010011 supported; 0: treated as illegal
//  EN_JAL    1  1: op 1101111 supported; 0: treated as illegal
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous, active-low reset
//  op         in   7  opcode from instruction register
//  zero       in   1  ALU zero flag (valid in BEQ state)
//  mem_ready  in   1  memory access complete this cycle
//  PCWrite    out  1  PC load enable = PCUpdate | (Branch & zero)
//  AdrSrc     out  1  0: PC, 1: ALUOut to memory address
//  MemWrite   out  1  data memory write strobe
//  IRWrite    out  1  instruction register/OldPC load enable
//  RegWrite   out  1  register file write enable
//  ResultSrc  out  2  00 ALUOut, 01 mem data, 10 ALUResult
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 RD1
//  ALUSrcB    out  2  00 RD2, 01 ImmExt, 10 constant 4
//  ALUOp      out  2  00 add, 01 sub (branch), 10 funct-decoded
//  ImmSrc     out  2  combinational from op: I/load 00, S 01, B 10, J 11, others 00
//  instr_done out  1  1-cycle pulse on the final state of each instruction
//  illegal    out  1  high while in TRAP
// BEHAVIOUR
//  - State register: async reset to FETCH. All outputs except ImmSrc are Moore-decoded from state.
//    While rst_n=0, every enable (PCWrite, MemWrite, IRWrite, RegWrite) and instr_done/illegal is 0.
//  - Outputs not listed for a state are 0.
//  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//    IRWrite=PCUpdate=rdy (rdy=mem_ready if MEM_WAIT, else 1).
//    Next state is DECODE if rdy, otherwise FETCH.
//  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precomputed). Next state by op:
//    0000011/0100011 -> MEMADR
//    0110011 -> EXECR
//    0010011 -> EXECI
//    1101111 -> JAL
//    1100011 -> BEQ
//    anything else (or a disabled opcode) -> TRAP
//  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for a load, MEMWRITE for a store.
//  - MEMREAD: AdrSrc=1. Next state is MEMWB when rdy, otherwise MEMREAD.
//  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next state is FETCH.
//  - MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle spent in the state.
//    Next state is FETCH when rdy (instr_done=1 in that cycle), otherwise MEMWRITE.
//  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
//    Both go to ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next state is FETCH.
//  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB.
//  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
//    Next state is FETCH. PCWrite=zero in this state.
//  - TRAP: illegal=1, all enables 0. Stays in TRAP until rst_n is asserted.
//  - Latencies at mem_ready=1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//  - mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
//  - Reset asserted mid-instruction: state goes to FETCH immediately; no partial writeback occurs.
//  - op is sampled only in DECODE and MEMADR; the IR must hold op stable from IRWrite until FETCH.
//  - Unused state encodings recover to FETCH on the next clock.
// TESTING
//  - Reset, then lw (op 0000011) with mem_ready=1:
//    states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5; instr_done once.
//  - sw with MEM_WAIT=1, mem_ready low for 3 cycles in MEMWRITE:
//    MemWrite held 4 cycles, no RegWrite, then returns to FETCH.
//  - beq with zero=1 -> PCWrite=1 in cycle 3; repeat with zero=0 -> PCWrite=0 throughout BEQ.
//  - op 0010011 with EN_ITYPE=0 -> TRAP after DECODE, illegal=1, enables stay 0 for 10 cycles;
//    rst_n=0 -> FETCH.
//  - jal: PCWrite=1 in the JAL state, RegWrite=1 with ResultSrc=00 in the next cycle, instr_done=1.
//  - Drop rst_n in MEMREAD: outputs go to 0 asynchronously; after release, fetch restarts with IRWrite=1.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Opcode/status inputs and datapath control outputs of the multicycle main controller.
// master = controller side, slave = datapath side.
interface multicycle_main_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/mem/writeback.
// 3-5 cycles per instruction; FETCH/MEMREAD/MEMWRITE stall on mem_ready when MEM_WAIT=1.
module multicycle_main_fsm #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EN_ITYPE = 1'b1,
  parameter bit EN_JAL   = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_main_fsm_if.master bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
  } state_t;

  state_t     state, stateNext;
  logic       rdy;
  logic       pcUpdate, branch, irWrite, regWrite, memWrite;
  logic       adrSrc, instrDone, illegalSt;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;

  assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = FETCH;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    adrSrc    = 1'b0;
    instrDone = 1'b0;
    illegalSt = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    case (state)
      FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = rdy;
        pcUpdate  = rdy;
        stateNext = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here from OldPC + immediate.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: stateNext = MEMADR;
          OP_RTYPE:          stateNext = EXECR;
          OP_ITYPE:          stateNext = EN_ITYPE ? EXECI : TRAP;
          OP_JAL:            stateNext = EN_JAL ? JAL : TRAP;
          OP_BRANCH:         stateNext = BEQ;
          default:           stateNext = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        stateNext = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adrSrc    = 1'b1;
        stateNext = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = rdy;
        stateNext = rdy ? FETCH : MEMWRITE;
      end
      EXECR: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b10;
        stateNext = ALUWB;
      end
      EXECI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluOp     = 2'b10;
        stateNext = ALUWB;
      end
      ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        stateNext = ALUWB;
      end
      BEQ: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      TRAP: begin
        illegalSt = 1'b1;
        stateNext = TRAP;
      end
      default: stateNext = FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_STORE:  bus.ImmSrc = 2'b01;
      OP_BRANCH: bus.ImmSrc = 2'b10;
      OP_JAL:    bus.ImmSrc = 2'b11;
      default:   bus.ImmSrc = 2'b00;
    endcase
  end

  // FETCH enables follow mem_ready, so enables are masked while reset is held.
  assign bus.PCWrite    = rst_n & (pcUpdate | (branch & bus.zero));
  assign bus.IRWrite    = rst_n & irWrite;
  assign bus.RegWrite   = rst_n & regWrite;
  assign bus.MemWrite   = rst_n & memWrite;
  assign bus.instr_done = rst_n & instrDone;
  assign bus.illegal    = rst_n & illegalSt;
  assign bus.AdrSrc     = adrSrc;
  assign bus.ResultSrc  = resultSrc;
  assign bus.ALUSrcA    = aluSrcA;
  assign bus.ALUSrcB    = aluSrcB;
  assign bus.ALUOp      = aluOp;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized instruction-level bench for multicycle_main_fsm (stall and no-stall configs).
// Expected per-cycle control vectors are queued by stimulus and checked by a negedge monitor.
module tb_multicycle_main_fsm;
  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic [1:0] imm;
    logic       done;
    logic       ill;
  } ctl_t;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic clk = 1'b0;
  logic rstA_n, rstB_n;

  multicycle_main_fsm_if ifA ();
  multicycle_main_fsm_if ifB ();

  multicycle_main_fsm #(.MEM_WAIT(1'b1), .EN_ITYPE(1'b1), .EN_JAL(1'b1)) dutA (
    .clk(clk), .rst_n(rstA_n), .bus(ifA.master)
  );
  multicycle_main_fsm #(.MEM_WAIT(1'b0), .EN_ITYPE(1'b0), .EN_JAL(1'b0)) dutB (
    .clk(clk), .rst_n(rstB_n), .bus(ifB.master)
  );

  always #5 clk = ~clk;

  ctl_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   dutSel = 0;
  logic [6:0] curOp;
  logic curZero, curRdy, curRst;
  bit   cfgMemWait, cfgEnI, cfgEnJ;
  logic [6:0] opTab [0:12];

  ctl_t actA, actB;
  assign actA = {ifA.PCWrite, ifA.AdrSrc, ifA.MemWrite, ifA.IRWrite, ifA.RegWrite, ifA.ResultSrc,
                 ifA.ALUSrcA, ifA.ALUSrcB, ifA.ALUOp, ifA.ImmSrc, ifA.instr_done, ifA.illegal};
  assign actB = {ifB.PCWrite, ifB.AdrSrc, ifB.MemWrite, ifB.IRWrite, ifB.RegWrite, ifB.ResultSrc,
                 ifB.ALUSrcA, ifB.ALUSrcB, ifB.ALUOp, ifB.ImmSrc, ifB.instr_done, ifB.illegal};

  always @(negedge clk) begin
    ctl_t e;
    ctl_t a;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = (dutSel == 0) ? actA : actB;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL ctl dut%0d vec %0d op=%b: got %b want %b (pcw adr mw irw rw rs sa sb aop imm done ill)",
                 dutSel, vectors, curOp, a, e);
      end
    end
  end

  function automatic logic [1:0] immOf(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_B:    return 2'b10;
      OP_J:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic ctl_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                              input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [1:0] aop, input logic done,
                              input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, immOf(curOp), done, ill};
  endfunction

  task automatic step(input ctl_t e);
    if (dutSel == 0) begin
      ifA.op = curOp; ifA.zero = curZero; ifA.mem_ready = curRdy; rstA_n = curRst;
    end else begin
      ifB.op = curOp; ifB.zero = curZero; ifB.mem_ready = curRdy; rstB_n = curRst;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    curZero = 1'($urandom);
    curRdy  = 1'($urandom);
  endtask

  // Reset looks like FETCH on the muxes with every enable forced off.
  task automatic doReset(input int n);
    curRst = 1'b0;
    for (int i = 0; i < n; i++) begin
      rnd();
      step(mk(N, N, N, N, N, 2'b10, 2'b00, 2'b10, 2'b00, N, N));
    end
    curRst = 1'b1;
  endtask

  task automatic fetchPhase();
    int w;
    w = cfgMemWait ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < w; i++) begin
      rnd(); curRdy = 1'b0;
      step(mk(N, N, N, N, N, 2'b10, 2'b00, 2'b10, 2'b00, N, N));
    end
    rnd();
    if (cfgMemWait) curRdy = 1'b1;
    step(mk(Y, N, N, Y, N, 2'b10, 2'b00, 2'b10, 2'b00, N, N));
  endtask

  task automatic aluWb();
    rnd();
    step(mk(N, N, N, N, Y, 2'b00, 2'b00, 2'b00, 2'b00, Y, N));
  endtask

  task automatic runInstr(input logic [6:0] op, input int zsel, input bit abortMem);
    int  w;
    bit  isSw;
    curOp = op;
    isSw  = (op == OP_SW);
    fetchPhase();
    rnd();
    step(mk(N, N, N, N, N, 2'b00, 2'b01, 2'b01, 2'b00, N, N));
    if (op == OP_LW || op == OP_SW) begin
      rnd();
      step(mk(N, N, N, N, N, 2'b00, 2'b10, 2'b01, 2'b00, N, N));
      w = cfgMemWait ? $urandom_range(0, 3) : 0;
      for (int i = 0; i < w; i++) begin
        rnd(); curRdy = 1'b0;
        step(mk(N, Y, isSw, N, N, 2'b00, 2'b00, 2'b00, 2'b00, N, N));
      end
      if (abortMem) begin
        doReset(2);
        return;
      end
      rnd();
      if (cfgMemWait) curRdy = 1'b1;
      step(mk(N, Y, isSw, N, N, 2'b00, 2'b00, 2'b00, 2'b00, isSw, N));
      if (!isSw) begin
        rnd();
        step(mk(N, N, N, N, Y, 2'b01, 2'b00, 2'b00, 2'b00, Y, N));
      end
    end else if (op == OP_R || (op == OP_I && cfgEnI)) begin
      rnd();
      step(mk(N, N, N, N, N, 2'b00, 2'b10, (op == OP_R) ? 2'b00 : 2'b01, 2'b10, N, N));
      aluWb();
    end else if (op == OP_J && cfgEnJ) begin
      rnd();
      step(mk(Y, N, N, N, N, 2'b00, 2'b01, 2'b10, 2'b00, N, N));
      aluWb();
    end else if (op == OP_B) begin
      rnd();
      if (zsel >= 0) curZero = zsel[0];
      step(mk(curZero, N, N, N, N, 2'b00, 2'b10, 2'b00, 2'b01, Y, N));
    end else begin
      for (int i = 0; i < 10; i++) begin
        rnd();
        step(mk(N, N, N, N, N, 2'b00, 2'b00, 2'b00, 2'b00, N, Y));
      end
      doReset(2);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expQ.size() > 0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (expQ.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    opTab = '{OP_LW, OP_SW, OP_R, OP_I, OP_J, OP_B, OP_LW, OP_SW, OP_R, OP_I, OP_J, OP_B, OP_BAD};
    curOp = OP_LW; curZero = 1'b0; curRdy = 1'b0; curRst = 1'b0;
    rstA_n = 1'b0; rstB_n = 1'b0;
    ifA.op = OP_LW; ifA.zero = 1'b0; ifA.mem_ready = 1'b0;
    ifB.op = OP_LW; ifB.zero = 1'b0; ifB.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    dutSel = 0; cfgMemWait = 1'b1; cfgEnI = 1'b1; cfgEnJ = 1'b1;
    doReset(2);
    runInstr(OP_LW, -1, 1'b0);
    runInstr(OP_SW, -1, 1'b0);
    runInstr(OP_B, 1, 1'b0);
    runInstr(OP_B, 0, 1'b0);
    runInstr(OP_J, -1, 1'b0);
    runInstr(OP_R, -1, 1'b0);
    runInstr(OP_I, -1, 1'b0);
    runInstr(OP_LW, -1, 1'b1);
    for (int n = 0; n < 60; n++) runInstr(opTab[$urandom_range(0, 12)], -1, 1'b0);
    runInstr(OP_BAD, -1, 1'b0);
    runInstr(OP_SW, -1, 1'b0);
    drain();

    rstA_n = 1'b0;
    dutSel = 1; cfgMemWait = 1'b0; cfgEnI = 1'b0; cfgEnJ = 1'b0;
    doReset(2);
    runInstr(OP_I, -1, 1'b0);
    runInstr(OP_J, -1, 1'b0);
    runInstr(OP_LW, -1, 1'b0);
    runInstr(OP_SW, -1, 1'b0);
    runInstr(OP_B, 1, 1'b0);
    runInstr(OP_B, 0, 1'b0);
    runInstr(OP_R, -1, 1'b0);
    for (int n = 0; n < 30; n++) runInstr(opTab[$urandom_range(0, 12)], -1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
